// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared constants and types for the MEM-stage data memory responder.
//   RegBusWidth     : width of the address/data bus
//   ZeroWord        : all-zero bus word
//   RstEnable       : level of rst_n that holds the block in reset
//   ChipEnable      : level of mem_ce_i that marks a valid request
//   WriteEnable     : level of mem_we_i that marks a store
//   DataMemNumLog2  : default log2 of storage depth in 32-bit words
//   dm_state_e      : responder FSM states (DmIdle / DmWait / DmAck)
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int          RegBusWidth    = 32;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam logic        RstEnable      = 1'b0;
  localparam logic        ChipEnable     = 1'b1;
  localparam logic        WriteEnable    = 1'b1;
  localparam int          DataMemNumLog2 = 10;

  // Wait-state counter width; covers the supported 0..15 wait states.
  localparam int          WaitCntWidth   = 4;

  typedef enum logic [1:0] {
    DmIdle = 2'd0,
    DmWait = 2'd1,
    DmAck  = 2'd2
  } dm_state_e;

endpackage

// File: rtl/data_mem_responder_array.sv
// ---------------------------------------------------------------------------
// data_mem_array
// Word-addressed data storage built from four byte-wide banks.
//   clk      : clock, all accesses on the rising edge
//   rd_en    : read strobe; rd_data only changes on a strobed edge
//   rd_addr  : word index to read
//   rd_data  : registered read data (holds between reads)
//   wr_en    : write strobe
//   wr_addr  : word index to write
//   wr_sel   : byte-lane enables (sel[3] -> bits 31:24 ... sel[0] -> 7:0)
//   wr_data  : write data
// Storage and the read register are intentionally not reset.
// ---------------------------------------------------------------------------
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DataMemNumLog2
) (
  input  logic                   clk,
  input  logic                   rd_en,
  input  logic [DEPTH_LOG2-1:0]  rd_addr,
  output logic [RegBusWidth-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [DEPTH_LOG2-1:0]  wr_addr,
  input  logic [3:0]             wr_sel,
  input  logic [RegBusWidth-1:0] wr_data
);

  localparam int Depth = 2 ** DEPTH_LOG2;

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] bank [Depth];
    logic [7:0] rd_byte;

    // One bank per byte lane: independent byte write enable, shared
    // word index, and a read register that only updates on request.
    always_ff @(posedge clk) begin
      if (wr_en && wr_sel[lane]) begin
        bank[wr_addr] <= wr_data[8*lane +: 8];
      end
      if (rd_en) begin
        rd_byte <= bank[rd_addr];
      end
    end

    assign rd_data[8*lane +: 8] = rd_byte;
  end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Responder for the MEM-stage load/store port. Captures a word request,
// waits WAIT_CYCLES cycles, then acknowledges for one cycle (stores commit
// at the edge that ends the ack cycle, load data appears with the ack).
// Parameters:
//   DEPTH_LOG2  : log2 of storage depth in words
//   WAIT_CYCLES : wait states between capture and ack (0..15)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   mem_ce_i    : request valid, held until ack
//   mem_we_i    : 1 = store, 0 = load
//   mem_addr_i  : byte address (word index = addr[DEPTH_LOG2+1:2])
//   mem_sel_i   : store byte-lane enables
//   mem_data_i  : store data
//   mem_data_o  : load data, held until the next load ack
//   mem_ack_o   : one-cycle completion strobe
//   stallreq_o  : pipeline stall request (mem_ce_i & ~mem_ack_o)
// ---------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = DataMemNumLog2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_ce_i,
  input  logic                   mem_we_i,
  input  logic [RegBusWidth-1:0] mem_addr_i,
  input  logic [3:0]             mem_sel_i,
  input  logic [RegBusWidth-1:0] mem_data_i,
  output logic [RegBusWidth-1:0] mem_data_o,
  output logic                   mem_ack_o,
  output logic                   stallreq_o
);

  localparam logic [WaitCntWidth-1:0] WaitLoad = WaitCntWidth'(WAIT_CYCLES);

  dm_state_e                state_q, state_d;
  logic [WaitCntWidth-1:0]  wait_cnt_q, wait_cnt_d;

  logic                     req_we_q;
  logic [DEPTH_LOG2-1:0]    req_idx_q;
  logic [3:0]               req_sel_q;
  logic [RegBusWidth-1:0]   req_data_q;

  logic                     capture;
  logic                     rd_en;
  logic [DEPTH_LOG2-1:0]    rd_idx;
  logic [RegBusWidth-1:0]   rd_data;
  logic                     wr_en;
  logic                     load_valid_q;

  logic [DEPTH_LOG2-1:0]    addr_idx;
  logic                     unused_addr_bits;

  // Only the word-index bits of the address matter: the byte offset is
  // checked upstream and higher bits alias modulo the storage size.
  assign addr_idx         = mem_addr_i[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{mem_addr_i[RegBusWidth-1:DEPTH_LOG2+2], mem_addr_i[1:0]};

  // State, counter and request registers. The request is captured only in
  // IDLE so later changes on the bus cannot corrupt an outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      state_q    <= DmIdle;
      wait_cnt_q <= '0;
      req_we_q   <= 1'b0;
      req_idx_q  <= '0;
      req_sel_q  <= '0;
      req_data_q <= ZeroWord;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (capture) begin
        req_we_q   <= mem_we_i;
        req_idx_q  <= addr_idx;
        req_sel_q  <= mem_sel_i;
        req_data_q <= mem_data_i;
      end
    end
  end

  // Next-state logic. The array read is issued on the edge that enters
  // ACK so load data is valid during the ack cycle; with zero wait states
  // that edge is also the capture edge, so the read uses the live address.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    capture    = 1'b0;
    rd_en      = 1'b0;
    rd_idx     = req_idx_q;
    case (state_q)
      DmIdle: begin
        if (mem_ce_i == ChipEnable) begin
          capture    = 1'b1;
          wait_cnt_d = WaitLoad;
          if (WAIT_CYCLES > 0) begin
            state_d = DmWait;
          end else begin
            state_d = DmAck;
            rd_en   = (mem_we_i != WriteEnable);
            rd_idx  = addr_idx;
          end
        end
      end
      DmWait: begin
        if (mem_ce_i != ChipEnable) begin
          state_d    = DmIdle;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
          if (wait_cnt_q == 1) begin
            state_d = DmAck;
            rd_en   = (req_we_q != WriteEnable);
          end
        end
      end
      DmAck: begin
        state_d = DmIdle;
      end
      default: begin
        state_d = DmIdle;
      end
    endcase
  end

  // Output data stays at zero after reset until the first load completes,
  // because the storage read register itself carries no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      load_valid_q <= 1'b0;
    end else if (rd_en) begin
      load_valid_q <= 1'b1;
    end
  end

  assign wr_en      = (state_q == DmAck) && (req_we_q == WriteEnable);
  assign mem_ack_o  = (state_q == DmAck);
  assign stallreq_o = mem_ce_i & ~mem_ack_o;
  assign mem_data_o = load_valid_q ? rd_data : ZeroWord;

  data_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (req_idx_q),
    .wr_sel  (req_sel_q),
    .wr_data (req_data_q)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Drives three responder builds (WAIT_CYCLES = 1, 0, 3) with directed and
// random load/store traffic and compares ack timing, stall and load data
// against a word-array memory model kept in the bench.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int NumDut = 3;
  localparam int WOf [NumDut] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic        rst_n [NumDut];
  logic        ce    [NumDut];
  logic        we    [NumDut];
  logic [31:0] addr  [NumDut];
  logic [3:0]  sel   [NumDut];
  logic [31:0] din   [NumDut];
  logic [31:0] dout  [NumDut];
  logic        ack   [NumDut];
  logic        stall [NumDut];

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [NumDut][1024];
  logic [31:0] exp_dout  [NumDut];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n[0]), .mem_ce_i(ce[0]), .mem_we_i(we[0]),
    .mem_addr_i(addr[0]), .mem_sel_i(sel[0]), .mem_data_i(din[0]),
    .mem_data_o(dout[0]), .mem_ack_o(ack[0]), .stallreq_o(stall[0]));

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n[1]), .mem_ce_i(ce[1]), .mem_we_i(we[1]),
    .mem_addr_i(addr[1]), .mem_sel_i(sel[1]), .mem_data_i(din[1]),
    .mem_data_o(dout[1]), .mem_ack_o(ack[1]), .stallreq_o(stall[1]));

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n[2]), .mem_ce_i(ce[2]), .mem_we_i(we[2]),
    .mem_addr_i(addr[2]), .mem_sel_i(sel[2]), .mem_data_i(din[2]),
    .mem_data_o(dout[2]), .mem_ack_o(ack[2]), .stallreq_o(stall[2]));

  // Word slot of a byte address in a 1024-word memory that aliases.
  function automatic int wordSlot(input logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drop the request and let n cycles pass, expecting a quiet port.
  task automatic idleCycles(input int d, input int n);
    ce[d] = 1'b0;
    we[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_ack_d%0d", d), 32'(ack[d]), 32'd0);
      checkOutput($sformatf("idle_stall_d%0d", d), 32'(stall[d]), 32'd0);
    end
  endtask

  // Issue one request and follow it to its ack. Called at a negedge; when
  // b2b is set the caller is in the previous ack cycle and keeps ce high,
  // so the new request is only seen one cycle later. Returns in the ack
  // cycle with the request still on the bus.
  task automatic applyStimulus(input int d, input logic we_v, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] wd, input bit b2b);
    int  lat;
    bit  seen;
    logic [31:0] w;
    ce[d]   = 1'b1;
    we[d]   = we_v;
    addr[d] = a;
    sel[d]  = s;
    din[d]  = wd;
    if (b2b) @(negedge clk);
    else #1;
    lat  = 99;
    seen = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      if (ack[d] === 1'b1) begin
        lat  = k;
        seen = 1'b1;
        break;
      end
      checkOutput($sformatf("stall_wait_d%0d", d), 32'(stall[d]), 32'd1);
    end
    checkOutput($sformatf("latency_d%0d", d), 32'(lat), 32'(1 + WOf[d]));
    if (seen) begin
      checkOutput($sformatf("stall_ack_d%0d", d), 32'(stall[d]), 32'd0);
      if (we_v) begin
        w = model_mem[d][wordSlot(a)];
        for (int b = 0; b < 4; b++) begin
          if (s[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
        model_mem[d][wordSlot(a)] = w;
        checkOutput($sformatf("hold_dout_d%0d", d), dout[d], exp_dout[d]);
      end else begin
        exp_dout[d] = model_mem[d][wordSlot(a)];
        checkOutput($sformatf("load_d%0d_a%h", d, a), dout[d], exp_dout[d]);
      end
    end
  endtask

  int  cur_d;
  bit  live;
  bit  b2b;
  int  nd;
  logic [31:0] prior;
  logic [31:0] ra;

  initial begin
    for (int d = 0; d < NumDut; d++) begin
      rst_n[d] = 1'b0; ce[d] = 1'b0; we[d] = 1'b0;
      addr[d] = '0; sel[d] = '0; din[d] = '0; exp_dout[d] = '0;
    end

    // Reset values, and stall following ce while held in reset.
    @(negedge clk);
    for (int d = 0; d < NumDut; d++) begin
      checkOutput("rst_ack", 32'(ack[d]), 32'd0);
      checkOutput("rst_dout", dout[d], 32'd0);
      checkOutput("rst_stall_ce0", 32'(stall[d]), 32'd0);
      ce[d] = 1'b1;
      #1 checkOutput("rst_stall_ce1", 32'(stall[d]), 32'd1);
      ce[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < NumDut; d++) rst_n[d] = 1'b1;
    @(negedge clk);

    // Fill the first 32 words of every build with known data.
    for (int d = 0; d < NumDut; d++) begin
      for (int i = 0; i < 32; i++) begin
        applyStimulus(d, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0);
        idleCycles(d, 1);
      end
    end

    // Store then load, one wait state.
    applyStimulus(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0); idleCycles(0, 1);
    applyStimulus(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    checkOutput("tp_load_10", dout[0], 32'hDEADBEEF);
    idleCycles(0, 1);

    // Byte lanes and empty select.
    applyStimulus(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0); idleCycles(0, 1);
    applyStimulus(0, 1'b1, 32'h20, 4'b0100, 32'hAABBCCDD, 1'b0); idleCycles(0, 1);
    applyStimulus(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
    checkOutput("tp_lane_merge", dout[0], 32'h11BB3344);
    idleCycles(0, 1);
    applyStimulus(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0); idleCycles(0, 1);
    applyStimulus(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
    checkOutput("tp_sel_zero", dout[0], 32'h11BB3344);
    idleCycles(0, 1);

    // Aliasing and ignored byte offset.
    applyStimulus(0, 1'b1, 32'h00001008, 4'hF, 32'h5A5A5A5A, 1'b0); idleCycles(0, 1);
    applyStimulus(0, 1'b0, 32'h00000008, 4'hF, 32'h0, 1'b0);
    checkOutput("tp_alias", dout[0], 32'h5A5A5A5A);
    idleCycles(0, 1);
    applyStimulus(0, 1'b0, 32'h0000000B, 4'hF, 32'h0, 1'b0);
    checkOutput("tp_alias_off3", dout[0], 32'h5A5A5A5A);
    idleCycles(0, 1);

    // Zero wait states: single load, then back-to-back with ce held.
    applyStimulus(1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h4, 4'hF, 32'h0, 1'b1);
    idleCycles(1, 2);

    // Abort: ce drops in the second wait cycle of a store.
    prior = model_mem[2][16];
    ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; sel[2] = 4'hF; din[2] = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("abort_ack_w1", 32'(ack[2]), 32'd0);
    @(negedge clk);
    checkOutput("abort_ack_w2", 32'(ack[2]), 32'd0);
    ce[2] = 1'b0; we[2] = 1'b0;
    @(negedge clk);
    checkOutput("abort_ack_after", 32'(ack[2]), 32'd0);
    applyStimulus(2, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
    checkOutput("abort_no_write", dout[2], prior);
    idleCycles(2, 1);

    // Reset during the wait phase of a store.
    applyStimulus(2, 1'b1, 32'h44, 4'hF, 32'h12345678, 1'b0); idleCycles(2, 1);
    applyStimulus(2, 1'b0, 32'h44, 4'hF, 32'h0, 1'b0); idleCycles(2, 1);
    ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h44; sel[2] = 4'hF; din[2] = 32'h87654321;
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    checkOutput("midrst_ack", 32'(ack[2]), 32'd0);
    checkOutput("midrst_dout", dout[2], 32'd0);
    exp_dout[2] = 32'd0;
    ce[2] = 1'b0; we[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(negedge clk);
    applyStimulus(2, 1'b0, 32'h44, 4'hF, 32'h0, 1'b0);
    checkOutput("midrst_no_write", dout[2], 32'h12345678);
    idleCycles(2, 1);

    // Random traffic across all three builds.
    live  = 1'b0;
    cur_d = 0;
    for (int it = 0; it < 200; it++) begin
      nd = $urandom_range(0, NumDut - 1);
      if (live && nd == cur_d && $urandom_range(0, 1) == 1) begin
        b2b = 1'b1;
      end else begin
        if (live) idleCycles(cur_d, $urandom_range(1, 2));
        b2b = 1'b0;
      end
      ra = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
      applyStimulus(nd, 1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom, b2b);
      cur_d = nd;
      live  = 1'b1;
    end
    idleCycles(cur_d, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the MEM stage's load/store port. It accepts a word request (chip-enable, write-enable, byte selects, address, write data), inserts a configurable number of wait states, then completes the write or returns read data with a one-cycle acknowledge. While a request is outstanding it raises a stall request toward the pipeline controller, so MEM holds its request until completion. It sits between the MEM stage and the on-chip data RAM, on the responder side of the MEM-stage memory interface.

## Interface
- DEPTH_LOG2, 10, log2 of storage depth in 32-bit words (default 1024 words = 4 KiB)
- WAIT_CYCLES, 1, wait states inserted between request capture and acknowledge (0..15)
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low (`RstEnable` = 1'b0)
- mem_ce_i  input  1  request valid (`ChipEnable`); held high by the initiator until ack
- mem_we_i  input  1  1 = store, 0 = load
- mem_addr_i  input  `RegBus`  byte address; word index = addr[DEPTH_LOG2+1:2]
- mem_sel_i  input  4  byte-lane enables for stores
- mem_data_i  input  `RegBus`  store data
- mem_data_o  output  `RegBus`  load data, valid while mem_ack_o = 1
- mem_ack_o  output  1  one-cycle completion strobe
- stallreq_o  output  1  pipeline stall request

## Operation
- FSM states: IDLE, WAIT, ACK. Reset state IDLE.
- IDLE: on a rising edge with mem_ce_i = 1, capture we/addr/sel/data into request registers and load wait counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES > 0, else ACK. In all other cases remain in IDLE.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACK. If mem_ce_i drops, abort: go to IDLE with no write and no ack.
- ACK: mem_ack_o = 1 for exactly one cycle, then go to IDLE.
  - Store: the write commits at the edge that ends the ACK cycle.
  - Load: mem_data_o is loaded at the edge entering ACK.
- Byte lanes are big-endian: sel[3] writes bits 31:24 (addr offset 0), sel[2] writes 23:16, sel[1] writes 15:8, sel[0] writes 7:0.
- A store with sel = 4'b0000 still completes and acks, but leaves storage unchanged.
- Loads ignore sel and return the full word. The MEM stage performs lane extraction and sign extension.
- Addressing:
  - addr[1:0] is ignored; unaligned accesses are checked by the MEM stage.
  - Address bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo storage size.
- stallreq_o = mem_ce_i & ~mem_ack_o (combinational).
- mem_data_o holds its value until the next load ack.

## Timing
- Reset values: state IDLE, counter 0, mem_ack_o 0, mem_data_o `ZeroWord`, request registers 0. stallreq_o follows mem_ce_i.
- Storage contents are not reset.
- Latency: if mem_ce_i first rises in cycle N, mem_ack_o is high in cycle N+1+WAIT_CYCLES.
- Back-to-back: if mem_ce_i is still high in the cycle after ACK, it is treated as a new request. The initiator must change or drop its request in the ACK cycle.
- Reset mid-operation: the FSM returns to IDLE asynchronously, no ack is issued, and no write occurs if reset asserts before the commit edge.
- A load following a store to the same word returns the new data, because the commit edge precedes the next capture.
- Request inputs are not sampled in WAIT/ACK except mem_ce_i for abort. Changes to addr/data mid-request are ignored.

## Structure
- Shared constants live in defines.v:
  - existing: `RegBus`, `ZeroWord`, `RstEnable`, `ChipEnable`, `WriteEnable`
  - new: `DataMemNumLog2` (default for DEPTH_LOG2)
  - new: FSM state encodings `DmIdle`/`DmWait`/`DmAck`
- Sub-module data_mem_array holds four byte-wide banks of 2^DEPTH_LOG2 entries. It has a synchronous read port, a synchronous byte-enabled write port, and no reset. data_mem_responder owns the FSM, counter, request registers and handshake.

## Test plan
- Store, WAIT_CYCLES=1: ce=1, we=1, addr=0x10, sel=4'b1111, data=0xDEADBEEF. Require ack high exactly in cycle N+2 and stallreq_o high in N and N+1. A following load of 0x10 returns 0xDEADBEEF with ack.
- Byte lanes: store 0x11223344 (sel 1111) to 0x20, then store 0xAABBCCDD with sel 4'b0100. A load of 0x20 returns 0x11BB3344. A store with sel 0000 acks and leaves 0x11BB3344.
- WAIT_CYCLES=0 build: load of a pre-written word acks in cycle N+1. Back-to-back loads of 0x0 and 0x4, with ce held high, each get one ack at a 2-cycle spacing.
- Abort: WAIT_CYCLES=3, store 0xCAFEF00D to 0x40, drop ce in the second WAIT cycle. Require no ack, state IDLE next cycle, and a later load of 0x40 returns the prior value.
- Aliasing: DEPTH_LOG2=10, store 0x5A5A5A5A to 0x00001008. A load of 0x00000008 returns 0x5A5A5A5A, and addr[1:0]=2'b11 gives the same result.
- Reset mid-op: assert rst_n low during WAIT of a store. Require ack 0 and mem_data_o 0 immediately, no write committed, and normal operation after release.
